axi4_slave_write_responder: RTL and testbench

- Synthesizable AXI4 slave-side write responder: the responding end of the write address, write data and write response channels driven by the master AVIP.
- Accepts one AW request, absorbs its W burst into an internal byte-wide memory, then returns one B response.
- Used as a DUT stand-in and as a loopback target for master-agent regression.
- Exposes a byte read-back port so the bench can check memory contents.

---
 rtl/axi4_slave_write_responder.sv | 161 ++++++++++++++++
 tb/tb_axi4_slave_write_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: one AW, its W burst absorbed into a byte memory, one B.
// Byte back-door read port lets a bench inspect memory contents.
module axi4_slave_write_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 16,
    parameter int MIN_ADDRESS   = 0,
    parameter int MAX_ADDRESS   = 4095
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awlock,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDRESS_WIDTH-1:0]  mem_rd_addr,
    output logic [7:0]                mem_rd_data
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LG_B  = $clog2(BYTES);
    localparam int DEPTH = MAX_ADDRESS - MIN_ADDRESS + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] MIN_A = ADDRESS_WIDTH'(MIN_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] SPAN  = ADDRESS_WIDTH'(MAX_ADDRESS - MIN_ADDRESS);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } aw_req_t;

    state_t                     state;
    aw_req_t                    req;
    logic [ADDRESS_WIDTH-1:0]   beat_addr;
    logic [7:0]                 cnt;
    logic                       slv_err, dec_err;
    logic [7:0]                 mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0]   size_b, aligned, win_end, lane_base;
    logic [ADDRESS_WIDTH-1:0]   wrap_len, wrap_base, next_addr;
    logic [BYTES-1:0]           lane_act, lane_rng, lane_we;
    logic [BYTES-1:0][ADDRESS_WIDTH-1:0] lane_off;
    logic                       w_fire, last, slv_now, dec_beat;
    logic [ADDRESS_WIDTH-1:0]   rd_off;

    always_comb begin
        size_b    = ADDRESS_WIDTH'(1) << req.size;
        aligned   = beat_addr & ~(size_b - ADDRESS_WIDTH'(1));
        win_end   = aligned + size_b;
        lane_base = beat_addr & ~ADDRESS_WIDTH'(BYTES - 1);
        wrap_len  = ADDRESS_WIDTH'({1'b0, req.len} + 9'd1) << req.size;
        wrap_base = beat_addr & ~(wrap_len - ADDRESS_WIDTH'(1));
        case (req.burst)
            2'b00:   next_addr = beat_addr;
            2'b10:   next_addr = (win_end == wrap_base + wrap_len) ? wrap_base : win_end;
            default: next_addr = win_end;
        endcase
    end

    // Per-lane byte address: active within the beat window, in range of the decoded space.
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic [ADDRESS_WIDTH-1:0] byte_addr;
        assign byte_addr   = lane_base + ADDRESS_WIDTH'(i);
        assign lane_act[i] = wstrb[i] && (byte_addr >= beat_addr) && (byte_addr < win_end);
        assign lane_off[i] = byte_addr - MIN_A;
        assign lane_rng[i] = lane_off[i] <= SPAN;
    end

    assign w_fire   = wvalid && wready;
    assign last     = (cnt == req.len);
    assign slv_now  = slv_err || (wlast != last);
    assign dec_beat = |(lane_act & ~lane_rng);
    assign lane_we  = lane_act & lane_rng & {BYTES{~slv_now}};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= 2'b00;
            req       <= '0;
            beat_addr <= '0;
            cnt       <= '0;
            slv_err   <= 1'b0;
            dec_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid && awready) begin
                        req       <= '{id: awid, len: awlen, size: awsize, burst: awburst};
                        beat_addr <= awaddr;
                        cnt       <= '0;
                        slv_err   <= (awburst == 2'b11) || (awsize > 3'(LG_B)) ||
                                     (awburst == 2'b10 && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
                        dec_err   <= 1'b0;
                        awready   <= 1'b0;
                        wready    <= 1'b1;
                        state     <= DATA;
                    end else begin
                        awready   <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        cnt       <= cnt + 8'd1;
                        beat_addr <= next_addr;
                        slv_err   <= slv_now;
                        dec_err   <= dec_err || dec_beat;
                        if (last) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= req.id;
                            bresp  <= slv_now ? 2'b10 : (dec_err || dec_beat) ? 2'b11 : 2'b00;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately left out of reset so contents survive an abandoned burst.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int i = 0; i < BYTES; i++)
                if (lane_we[i]) mem[lane_off[i][IDX_W-1:0]] <= wdata[8*i +: 8];
        end
    end

    assign rd_off      = mem_rd_addr - MIN_A;
    assign mem_rd_data = (rd_off <= SPAN) ? mem[rd_off[IDX_W-1:0]] : 8'h00;

    logic unused_ok;
    assign unused_ok = ^{awlock, rd_off, lane_off};
endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Bench for axi4_slave_write_responder: vector table plus backpressure and mid-burst reset sequences.
module tb_axi4_slave_write_responder;
    logic        aclk = 1'b0, areset = 1'b1;
    logic [15:0] awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awlock = 1'b0, awvalid = 1'b0, awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic [31:0] mem_rd_addr = '0;
    logic [7:0]  mem_rd_data;

    axi4_slave_write_responder dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [15:0]      id;
        logic [31:0]      d0, dstep;
        logic [3:0]       strb;
        bit               badlast;
        int               bhold;
        logic [1:0]       resp;
        int               nchk;
        logic [3:0][11:0] ca;
        logic [3:0][7:0]  cb;
    } vec_t;

    typedef struct {
        logic [15:0] id;
        logic [1:0]  resp;
    } bexp_t;

    bexp_t sbq[$];
    vec_t  tbl[12];
    int    n_cmp = 0, n_bad = 0;

    function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst, input logic [15:0] id, input logic [31:0] d0,
                                input logic [31:0] dstep, input bit badlast, input int bhold,
                                input logic [1:0] resp, input int nchk, input logic [47:0] ca,
                                input logic [31:0] cb);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
        v.d0 = d0; v.dstep = dstep; v.strb = 4'hF; v.badlast = badlast; v.bhold = bhold;
        v.resp = resp; v.nchk = nchk; v.ca = ca; v.cb = cb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, want);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            default: return bvalid;
        endcase
    endfunction

    // Waits at falling edges until the selected ready/valid is high, bounded.
    task automatic wait_hi(input int which, input string nm);
        int n = 0;
        @(negedge aclk);
        while (!pick(which) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!pick(which)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: still low after %0d cycles, required high", nm, n);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bexp_t e;
        @(posedge aclk); #1;
        awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
        awvalid = 1'b1;
        wait_hi(0, "awready");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        sbq.push_back('{id: v.id, resp: v.resp});
        for (int k = 0; k <= int'(v.len); k++) begin
            wdata  = v.d0 + 32'(k) * v.dstep;
            wstrb  = v.strb;
            wlast  = v.badlast ? 1'b1 : (k == int'(v.len));
            wvalid = 1'b1;
            wait_hi(1, "wready");
            @(posedge aclk); #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        @(negedge aclk);
        chk($sformatf("v%0d bvalid_latency", idx), 32'(bvalid), 32'd1);
        for (int h = 0; h < v.bhold; h++) begin
            @(negedge aclk);
            chk($sformatf("v%0d hold%0d bvalid", idx, h), 32'(bvalid), 32'd1);
            chk($sformatf("v%0d hold%0d bid", idx, h), 32'(bid), 32'(v.id));
            chk($sformatf("v%0d hold%0d bresp", idx, h), 32'(bresp), 32'(v.resp));
            chk($sformatf("v%0d hold%0d awready", idx, h), 32'(awready), 32'd0);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        wait_hi(2, "bvalid");
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d scoreboard: response with empty queue, required one entry", idx);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d bid", idx), 32'(bid), 32'(e.id));
            chk($sformatf("v%0d bresp", idx), 32'(bresp), 32'(e.resp));
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        chk($sformatf("v%0d awready_after_b", idx), 32'(awready), 32'd1);
        chk($sformatf("v%0d bvalid_after_b", idx), 32'(bvalid), 32'd0);
        for (int c = 0; c < v.nchk; c++) begin
            mem_rd_addr = {20'h0, v.ca[c]};
            #1;
            chk($sformatf("v%0d mem[%0h]", idx, v.ca[c]), 32'(mem_rd_data), 32'(v.cb[c]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(32'h10, 8'd0, 3'd2, 2'b01, 16'd5, 32'hDEADBEEF, 32'h0, 0, 0, 2'b00, 4,
                     {12'h013, 12'h012, 12'h011, 12'h010}, 32'hDEADBEEF);
        tbl[1]  = mk(32'h20, 8'd0, 3'd2, 2'b01, 16'd1, 32'hA0A1A2A3, 32'h0, 0, 0, 2'b00, 2,
                     {12'h0, 12'h0, 12'h023, 12'h020}, 32'h0000A0A3);
        tbl[2]  = mk(32'h21, 8'd1, 3'd0, 2'b00, 16'd2, 32'h11223344, 32'h44444444, 0, 0, 2'b00, 4,
                     {12'h023, 12'h022, 12'h021, 12'h020}, 32'hA0A177A3);
        tbl[3]  = mk(32'h38, 8'd3, 3'd2, 2'b10, 16'd3, 32'h10203040, 32'h01010101, 0, 10, 2'b00, 4,
                     {12'h037, 12'h030, 12'h03C, 12'h038}, 32'h13424140);
        tbl[4]  = mk(32'h40, 8'd0, 3'd2, 2'b01, 16'd4, 32'h01020304, 32'h0, 0, 0, 2'b00, 2,
                     {12'h0, 12'h0, 12'h043, 12'h040}, 32'h00000104);
        tbl[5]  = mk(32'h40, 8'd0, 3'd2, 2'b11, 16'd6, 32'hFFFFFFFF, 32'h0, 0, 0, 2'b10, 4,
                     {12'h043, 12'h042, 12'h041, 12'h040}, 32'h01020304);
        tbl[6]  = mk(32'hFFE, 8'd1, 3'd2, 2'b01, 16'd7, 32'hCAFEBABE, 32'h0, 0, 0, 2'b11, 2,
                     {12'h0, 12'h0, 12'hFFF, 12'hFFE}, 32'h0000CAFE);
        tbl[7]  = mk(32'h40, 8'd0, 3'd3, 2'b01, 16'd8, 32'h0, 32'h0, 0, 0, 2'b10, 1,
                     {12'h0, 12'h0, 12'h0, 12'h040}, 32'h00000004);
        tbl[8]  = mk(32'h40, 8'd2, 3'd2, 2'b10, 16'hABCD, 32'h0, 32'h0, 0, 0, 2'b10, 1,
                     {12'h0, 12'h0, 12'h0, 12'h040}, 32'h00000004);
        tbl[9]  = mk(32'h51, 8'd1, 3'd2, 2'b01, 16'd10, 32'hAABBCCDD, 32'h11111111, 0, 0, 2'b00, 4,
                     {12'h057, 12'h054, 12'h053, 12'h051}, 32'hBBEEAACC);
        tbl[10] = mk(32'h60, 8'd1, 3'd2, 2'b01, 16'd11, 32'h12345678, 32'h0, 1, 0, 2'b10, 0,
                     48'h0, 32'h0);
        tbl[11] = mk(32'h70, 8'd0, 3'd2, 2'b01, 16'hBEEF, 32'h5A5A5A5A, 32'h0, 0, 0, 2'b00, 1,
                     {12'h0, 12'h0, 12'h0, 12'h072}, 32'h0000005A);

        #12;
        chk("reset awready", 32'(awready), 32'd0);
        chk("reset wready", 32'(wready), 32'd0);
        chk("reset bvalid", 32'(bvalid), 32'd0);
        chk("reset bid", 32'(bid), 32'd0);
        chk("reset bresp", 32'(bresp), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("awready before first edge", 32'(awready), 32'd0);
        @(negedge aclk);
        chk("awready after release", 32'(awready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // Reset in the middle of beat 2 of an 8-beat burst abandons it with no response.
        @(posedge aclk); #1;
        awid = 16'h0099; awaddr = 32'h80; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        wait_hi(0, "rst awready");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wdata = 32'h0F0F0F00 + 32'(k); wstrb = 4'hF; wvalid = 1'b1;
            wait_hi(1, "rst wready");
            @(posedge aclk); #1;
        end
        wdata = 32'h0F0F0F02;
        #2 areset = 1'b1;
        #1;
        chk("midrst awready", 32'(awready), 32'd0);
        chk("midrst wready", 32'(wready), 32'd0);
        chk("midrst bvalid", 32'(bvalid), 32'd0);
        chk("midrst bid", 32'(bid), 32'd0);
        chk("midrst bresp", 32'(bresp), 32'd0);
        wvalid = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("midrst awready at release", 32'(awready), 32'd0);
        @(negedge aclk);
        chk("midrst awready one cycle later", 32'(awready), 32'd1);
        chk("midrst no response", 32'(bvalid), 32'd0);
        run_vec(mk(32'h90, 8'd0, 3'd2, 2'b01, 16'h0042, 32'h76543210, 32'h0, 0, 0, 2'b00, 2,
                   {12'h0, 12'h0, 12'h093, 12'h090}, 32'h00007610), 100);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
